// File: rtl/mem_responder_if.sv
// CPU-to-memory bus: command, address and store data from the initiator,
// load data plus completion/error pulses back from the responder.
interface mem_responder_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        bus_err;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ready, bus_err
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ready, bus_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: 256x16 RAM, LED register and switch port behind a
// wait-stated command bus that answers each access with a one-cycle ready pulse.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RAM_WORDS   = 256,
  parameter logic [8:0]  LED_ADDR    = 9'h100,
  parameter logic [8:0]  SW_ADDR     = 9'h140
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus,
  input  logic [7:0]     sw,
  output logic [7:0]     ledr
);
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int AW = $clog2(RAM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [1:0]     cmd_q;
  logic [8:0]     addr_q;
  logic [15:0]    wdata_q;
  logic [15:0]    ram [RAM_WORDS];
  logic [AW-1:0]  ram_idx;
  logic           access;
  logic           is_ram;
  logic           is_led;
  logic           is_sw;

  assign access  = (state == WAIT) && (cnt == 4'd0);
  assign ram_idx = addr_q[AW-1:0];
  assign is_ram  = 32'(addr_q) < RAM_WORDS;
  assign is_led  = addr_q == LED_ADDR;
  assign is_sw   = addr_q == SW_ADDR;

  // Address and store data only matter once a command is latched, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.mem_cmd != MNONE) begin
      addr_q  <= bus.mem_addr;
      wdata_q <= bus.write_data;
    end
  end

  // RAM write is gated by the live state, so a reset in WAIT suppresses it.
  always_ff @(posedge clk) begin
    if (access && cmd_q == MWRITE && is_ram) begin
      ram[ram_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      cmd_q         <= MNONE;
      bus.read_data <= 16'h0000;
      bus.mem_ready <= 1'b0;
      bus.bus_err   <= 1'b0;
      ledr          <= 8'h00;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.bus_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.mem_cmd != MNONE) begin
            cmd_q <= bus.mem_cmd;
            cnt   <= WAIT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state         <= RESP;
            bus.mem_ready <= 1'b1;
            case (cmd_q)
              MREAD: begin
                if (is_ram)      bus.read_data <= ram[ram_idx];
                else if (is_led) bus.read_data <= {8'h00, ledr};
                else if (is_sw)  bus.read_data <= {8'h00, sw};
                else begin
                  bus.read_data <= 16'h0000;
                  bus.bus_err   <= 1'b1;
                end
              end
              MWRITE: begin
                if (is_led)       ledr        <= wdata_q[7:0];
                else if (!is_ram) bus.bus_err <= 1'b1;
              end
              default: bus.bus_err <= 1'b1;
            endcase
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder at WAIT_CYCLES 1, 0 and 15,
// with a behavioural memory-map model predicting every response.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MRSV   = 2'b11;
  localparam logic [8:0] LED_A  = 9'h100;
  localparam logic [8:0] SW_A   = 9'h140;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  sw;
  logic [1:0]  cmd   [ND];
  logic [8:0]  addr  [ND];
  logic [15:0] wdata [ND];
  logic [15:0] rdata [ND];
  logic        rdy   [ND];
  logic        err   [ND];
  logic [7:0]  led   [ND];

  function automatic int wait_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mem_responder_if bus ();
    assign bus.mem_cmd    = cmd[g];
    assign bus.mem_addr   = addr[g];
    assign bus.write_data = wdata[g];
    assign rdata[g]       = bus.read_data;
    assign rdy[g]         = bus.mem_ready;
    assign err[g]         = bus.bus_err;
    mem_responder #(.WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 15))) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .sw    (sw),
      .ledr  (led[g])
    );
  end

  // Reference model: plain memory map per instance.
  logic [15:0] m_ram [ND][256];
  bit          m_vld [ND][256];
  logic [7:0]  m_led [ND];
  logic [15:0] m_rd  [ND];

  typedef struct {
    int          dut;
    longint      due;
    logic [15:0] rd;
    logic        err;
    logic [7:0]  led;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic   prev_rdy [ND] = '{default: 1'b0};

  always @(posedge clk) cyc++;

  function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rdy[d]) begin
        checks++;
        if (prev_rdy[d]) begin
          errors++;
          $display("FAIL double_ready dut%0d: got mem_ready high two cycles running, expected one", d);
        end
        if (q.size() == 0 || q[0].dut != d) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut%0d: got mem_ready=1 expected no response", d);
        end else begin
          mon_e = q.pop_front();
          chk("latency",   d, 32'(cyc), 32'(mon_e.due));
          chk("read_data", d, rdata[d], mon_e.rd);
          chk("bus_err",   d, err[d],   mon_e.err);
          chk("ledr",      d, led[d],   mon_e.led);
        end
      end else if (err[d]) begin
        checks++;
        errors++;
        $display("FAIL err_without_ready dut%0d: got bus_err=1 expected 0 outside mem_ready", d);
      end
      prev_rdy[d] = rdy[d];
    end
  end

  // Called just after a falling edge: predicts the response and presents the command.
  task automatic issue(int d, logic [1:0] c, logic [8:0] a, logic [15:0] wd);
    exp_t e;
    e.dut = d;
    e.due = cyc + wait_of(d) + 2;
    e.rd  = m_rd[d];
    e.err = 1'b0;
    case (c)
      MREAD: begin
        if (a < 9'd256)     e.rd = m_ram[d][a[7:0]];
        else if (a == LED_A) e.rd = {8'h00, m_led[d]};
        else if (a == SW_A)  e.rd = {8'h00, sw};
        else begin
          e.rd  = 16'h0000;
          e.err = 1'b1;
        end
      end
      MWRITE: begin
        if (a < 9'd256) begin
          m_ram[d][a[7:0]] = wd;
          m_vld[d][a[7:0]] = 1'b1;
        end else if (a == LED_A) begin
          m_led[d] = wd[7:0];
        end else begin
          e.err = 1'b1;
        end
      end
      default: e.err = 1'b1;
    endcase
    m_rd[d] = e.rd;
    e.led   = m_led[d];
    q.push_back(e);
    cmd[d]   = c;
    addr[d]  = a;
    wdata[d] = wd;
  endtask

  task automatic wait_empty(int d);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: got no mem_ready in %0d cycles, expected after %0d", d, n, wait_of(d) + 2);
      q.delete();
    end
  endtask

  task automatic release_bus(int d);
    cmd[d] = MNONE;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic do_op(int d, logic [1:0] c, logic [8:0] a, logic [15:0] wd);
    issue(d, c, a, wd);
    wait_empty(d);
    release_bus(d);
  endtask

  task automatic rand_op(int d);
    logic [1:0]  c;
    logic [8:0]  a;
    logic [15:0] wd;
    c = ($urandom_range(0, 9) == 0) ? MRSV : 2'($urandom_range(1, 2));
    case ($urandom_range(0, 9))
      0:       a = LED_A;
      1:       a = SW_A;
      2:       a = 9'($urandom);
      3:       a = 9'($urandom_range(240, 255));
      default: a = 9'($urandom_range(0, 15));
    endcase
    wd = 16'($urandom);
    if (c == MREAD && a < 9'd256 && !m_vld[d][a[7:0]]) c = MWRITE;
    sw = 8'($urandom);
    do_op(d, c, a, wd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sw = 8'h00;
    for (int d = 0; d < ND; d++) begin
      cmd[d]   = MNONE;
      addr[d]  = 9'h000;
      wdata[d] = 16'h0000;
      m_led[d] = 8'h00;
      m_rd[d]  = 16'h0000;
    end
    #2 reset = 1'b0;
    #6;
    for (int d = 0; d < ND; d++) begin
      chk("rst_read_data", d, rdata[d], 32'h0);
      chk("rst_mem_ready", d, rdy[d],   32'h0);
      chk("rst_bus_err",   d, err[d],   32'h0);
      chk("rst_ledr",      d, led[d],   32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed memory-map checks at WAIT_CYCLES=1
    do_op(0, MWRITE, 9'h005, 16'hBEEF);
    do_op(0, MREAD,  9'h005, 16'h0000);
    do_op(0, MWRITE, 9'h0FF, 16'h1234);
    do_op(0, MREAD,  9'h0FF, 16'h0000);
    do_op(0, MREAD,  LED_A,  16'h0000);
    do_op(0, MWRITE, LED_A,  16'hA55A);
    sw = 8'hC3;
    do_op(0, MREAD,  SW_A,   16'h0000);
    do_op(0, MREAD,  9'h1FF, 16'h0000);
    do_op(0, MRSV,   9'h005, 16'h7777);
    do_op(0, MWRITE, SW_A,   16'hDEAD);
    do_op(0, MREAD,  LED_A,  16'h0000);
    do_op(0, MREAD,  9'h005, 16'h0000);

    // Command left asserted through RESP is taken as a second request
    issue(0, MREAD, 9'h0FF, 16'h0000);
    wait_empty(0);
    @(negedge clk);
    issue(0, MREAD, 9'h0FF, 16'h0000);
    wait_empty(0);
    release_bus(0);

    for (int i = 0; i < 150; i++) rand_op(0);

    do_op(1, MWRITE, 9'h0FF, 16'h5A5A);
    do_op(1, MREAD,  9'h0FF, 16'h0000);
    for (int i = 0; i < 60; i++) rand_op(1);

    do_op(2, MWRITE, 9'h000, 16'hCAFE);
    do_op(2, MREAD,  9'h000, 16'h0000);
    for (int i = 0; i < 25; i++) rand_op(2);

    // Asynchronous reset while an LED write sits in WAIT
    issue(0, MWRITE, LED_A, 16'h00FF);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    q.delete();
    for (int d = 0; d < ND; d++) begin
      m_led[d] = 8'h00;
      m_rd[d]  = 16'h0000;
    end
    chk("mid_rst_ledr",      0, led[0], 32'h0);
    chk("mid_rst_mem_ready", 0, rdy[0], 32'h0);
    cmd[0] = MNONE;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_mem_ready", 0, rdy[0], 32'h0);
      chk("rst_hold_ledr",      0, led[0], 32'h0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ledr", 0, led[0], 32'h0);
    do_op(0, MREAD,  LED_A,  16'h0000);
    do_op(0, MREAD,  9'h0FF, 16'h0000);
    do_op(0, MWRITE, LED_A,  16'h0033);
    for (int i = 0; i < 20; i++) rand_op(0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
